// File: rtl/ascon_blk_buffer.sv
// ascon_blk_buffer: WB-loaded message buffer streaming padded ASCON rate blocks with in-place ciphertext writeback
module ascon_blk_buffer #(
   parameter int WB_W  = 32,
   parameter int BLK_W = 64,
   parameter int DEPTH = 32,
   parameter int LEN_W = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             wb_we,
   input  logic             wb_re,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WB_W-1:0]  wb_wdata,
   output logic [WB_W-1:0]  wb_rdata,
   output logic             wb_rvalid,
   input  logic             start,
   input  logic             ct_mode,
   input  logic [LEN_W-1:0] datalen,
   output logic             blk_valid,
   input  logic             blk_ready,
   output logic [BLK_W-1:0] blk_data,
   output logic [3:0]       blocksize,
   output logic             blk_last,
   input  logic             ct_valid,
   input  logic [BLK_W-1:0] ct_data,
   output logic             ct_ready,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int RATIO = BLK_W / WB_W;
   localparam int BPB   = BLK_W / 8;
   localparam int CW    = $clog2(RATIO + 1);
   localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'((DEPTH / RATIO) * BPB - 1);
   localparam logic [LEN_W-1:0] BPB_L   = LEN_W'(BPB);

   typedef enum logic [2:0] {IDLE, FETCH, OFFER, WAIT_CT, WB_CT, DONE} state_t;
   state_t state, state_n;

   logic [WB_W-1:0]  mem [DEPTH];
   logic [WB_W-1:0]  rd_q, wr_data;
   logic [AW-1:0]    ptr, rd_addr, wr_addr;
   logic [CW-1:0]    cnt;
   logic [LEN_W-1:0] remaining;
   logic [BLK_W-1:0] blk_reg;
   logic [3:0]       size_q, bs;
   logic             last_q, last, ct_m, rd_idle, idle, over, accept, we, fetch_end, wb_end;

   // Keeps the leading n bytes (big-endian order) and zeroes the rest.
   function automatic logic [BLK_W-1:0] keep_bytes(input logic [BLK_W-1:0] d, input logic [3:0] n);
      logic [BLK_W-1:0] r;
      r = d;
      for (int i = 0; i < BPB; i++)
         if (i >= int'(n)) r[BLK_W-1-8*i -: 8] = '0;
      return r;
   endfunction

   assign idle      = state == IDLE;
   assign over      = {1'b0, datalen} > MAX_LEN;
   assign bs        = remaining >= BPB_L ? 4'(BPB) : remaining[3:0];
   assign last      = remaining < BPB_L;
   assign accept    = state == OFFER && blk_ready;
   assign fetch_end = cnt == CW'(RATIO);
   assign wb_end    = cnt == CW'(RATIO - 1);
   assign rd_addr   = state == FETCH ? ptr + AW'(cnt) : wb_addr;
   assign we        = (idle && wb_we) || state == WB_CT;
   assign wr_addr   = state == WB_CT ? ptr + AW'(cnt) : wb_addr;
   assign wr_data   = state == WB_CT ? blk_reg[BLK_W-1-int'(cnt)*WB_W -: WB_W] : wb_wdata;

   assign blk_valid = state == OFFER;
   assign blk_data  = blk_valid ? keep_bytes(blk_reg, bs) : '0;
   assign blocksize = blk_valid ? bs : '0;
   assign blk_last  = blk_valid && last;
   assign ct_ready  = state == WAIT_CT;
   assign busy      = !idle && state != DONE;
   assign done      = state == DONE;
   assign wb_rdata  = wb_rvalid && rd_idle ? rd_q : '0;

   // Single-write single-read array with registered read; a same-cycle write is not seen by the read.
   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_q <= mem[rd_addr];
   end

   // State register.
   always_ff @(posedge clk or negedge nRST)
      if (!nRST) state <= IDLE;
      else state <= state_n;

   // Next-state logic.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start && !over ? FETCH : IDLE;
         FETCH:   state_n = fetch_end ? OFFER : FETCH;
         OFFER:   state_n = !blk_ready ? OFFER : ct_m ? WAIT_CT : last ? DONE : FETCH;
         WAIT_CT: state_n = ct_valid ? WB_CT : WAIT_CT;
         WB_CT:   state_n = !wb_end ? WB_CT : last_q ? DONE : FETCH;
         default: state_n = IDLE;
      endcase
   end

   // Block assembly, length bookkeeping, ciphertext capture and WB read status.
   always_ff @(posedge clk or negedge nRST)
      if (!nRST) begin
         err       <= 1'b0;
         wb_rvalid <= 1'b0;
         rd_idle   <= 1'b0;
         cnt       <= '0;
         ptr       <= '0;
         remaining <= '0;
         blk_reg   <= '0;
         size_q    <= '0;
         last_q    <= 1'b0;
         ct_m      <= 1'b0;
      end else begin
         err       <= idle && start && over;
         wb_rvalid <= wb_re;
         rd_idle   <= idle;
         cnt       <= (state == FETCH && !fetch_end) || (state == WB_CT && !wb_end) ? cnt + 1'b1 : '0;
         if (idle && start && !over) begin
            remaining <= datalen;
            ct_m      <= ct_mode;
            ptr       <= '0;
         end
         if (state == FETCH && cnt != '0) blk_reg[BLK_W-1-(int'(cnt)-1)*WB_W -: WB_W] <= rd_q;
         if (accept) begin
            remaining <= remaining - LEN_W'(bs);
            size_q    <= bs;
            last_q    <= last;
         end
         if ((accept && !ct_m) || (state == WB_CT && wb_end)) ptr <= ptr + AW'(RATIO);
         if (state == WAIT_CT && ct_valid) blk_reg <= keep_bytes(ct_data, size_q);
      end
endmodule

// File: tb/tb_ascon_blk_buffer.sv
// tb_ascon_blk_buffer: randomized and directed checks of the block buffer against a queue-based model
module tb_ascon_blk_buffer;
   logic        clk = 0, nRST = 0;
   logic        wb_we = 0, wb_re = 0, start = 0, ct_mode = 0, blk_ready, ct_valid;
   logic [4:0]  wb_addr = 0;
   logic [31:0] wb_wdata = 0, wb_rdata;
   logic        wb_rvalid, blk_valid, blk_last, ct_ready, busy, done, err;
   logic [7:0]  datalen = 0;
   logic [63:0] blk_data, ct_data;
   logic [3:0]  blocksize;

   typedef struct packed {logic [63:0] d; logic [3:0] s; logic l;} blk_t;
   blk_t        exp_q[$], acc_q[$];
   logic [31:0] mem_m [32];
   logic [3:0]  sz_arr [16];
   int          tests = 0, fails = 0, rdy_mode = 0, ct_delay = 0, ct_blk = 0;
   bit          ct_rand = 0;
   logic [63:0] ct_fixed = 0;

   always #5 clk = ~clk;

   ascon_blk_buffer dut (
      .clk(clk), .nRST(nRST), .wb_we(wb_we), .wb_re(wb_re), .wb_addr(wb_addr),
      .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_rvalid(wb_rvalid), .start(start),
      .ct_mode(ct_mode), .datalen(datalen), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blocksize(blocksize), .blk_last(blk_last), .ct_valid(ct_valid),
      .ct_data(ct_data), .ct_ready(ct_ready), .busy(busy), .done(done), .err(err)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] keep(input logic [63:0] d, input int s);
      return s >= 8 ? d : d & ~(64'hFFFF_FFFF_FFFF_FFFF >> (8 * s));
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      blk_ready = 0;
      forever begin
         tick;
         blk_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      int d;
      logic [63:0] c;
      ct_valid = 0;
      ct_data = 0;
      forever begin
         tick;
         ct_valid = 0;
         if (nRST && ct_ready) begin
            d = ct_rand ? int'($urandom_range(0, 3)) : ct_delay;
            repeat (d) begin
               chk("ct_ready_hold", ct_ready, 1);
               tick;
            end
            c = ct_rand ? {$urandom, $urandom} : ct_fixed;
            ct_data = c;
            ct_valid = 1;
            {mem_m[2*ct_blk], mem_m[2*ct_blk+1]} = keep(c, int'(sz_arr[ct_blk]));
            ct_blk++;
         end
      end
   end

   always @(negedge clk)
      if (nRST && blk_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL blk_unexpected: got block %0h, expected none", blk_data);
         end else begin
            chk("blk_data", blk_data, exp_q[0].d);
            chk("blocksize", blocksize, exp_q[0].s);
            chk("blk_last", blk_last, exp_q[0].l);
            if (blk_ready) begin
               acc_q.push_back(blk_t'({blk_data, blocksize, blk_last}));
               void'(exp_q.pop_front());
            end
         end
      end

   task automatic wb_write(input int a, input logic [31:0] d, input bit upd);
      wb_we = 1;
      wb_addr = 5'(a);
      wb_wdata = d;
      if (upd) mem_m[a] = d;
      tick;
      wb_we = 0;
   endtask

   task automatic wb_read(input int a, input logic [31:0] exp, input string name);
      wb_re = 1;
      wb_addr = 5'(a);
      @(negedge clk) chk({name, "_rvalid_early"}, wb_rvalid, 0);
      tick;
      wb_re = 0;
      @(negedge clk);
      chk({name, "_rvalid"}, wb_rvalid, 1);
      chk(name, wb_rdata, exp);
      tick;
   endtask

   task automatic wb_rw(input int a, input logic [31:0] d);
      logic [31:0] old;
      old = mem_m[a];
      mem_m[a] = d;
      wb_we = 1;
      wb_re = 1;
      wb_addr = 5'(a);
      wb_wdata = d;
      tick;
      wb_we = 0;
      wb_re = 0;
      @(negedge clk) chk("rw_old_data", wb_rdata, old);
      tick;
   endtask

   task automatic start_stream(input int len, input bit ctm, output int nb);
      int sz;
      nb = len / 8 + 1;
      exp_q.delete();
      acc_q.delete();
      for (int k = 0; k < nb; k++) begin
         sz = k < nb - 1 ? 8 : len % 8;
         sz_arr[k] = 4'(sz);
         exp_q.push_back(blk_t'({keep({mem_m[2*k], mem_m[2*k+1]}, sz), 4'(sz), k == nb - 1}));
      end
      ct_blk = 0;
      start = 1;
      datalen = 8'(len);
      ct_mode = ctm;
      tick;
      start = 0;
      ct_mode = !ctm;
      datalen = 8'($urandom);
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_valid;
      int n;
      n = 0;
      while (!blk_valid && n < 20) begin
         tick;
         n++;
      end
      chk("valid_latency", n, 3);
   endtask

   task automatic wait_done(input int nb);
      int n;
      n = 0;
      while (!done && n < 3000) begin
         tick;
         n++;
      end
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 0);
      chk("blocks_left", exp_q.size(), 0);
      chk("blocks_accepted", acc_q.size(), nb);
      tick;
      chk("done_pulse", done, 0);
   endtask

   initial begin
      int nb, len;
      bit ctm;
      logic [63:0] first_d;
      logic [3:0]  first_s;
      #1;
      tick;
      tick;
      chk("reset_outs", {wb_rdata, wb_rvalid, blk_valid, blk_data, blocksize, blk_last, ct_ready, busy, done, err}, 0);
      nRST = 1;
      tick;
      for (int a = 4; a < 32; a++) wb_write(a, $urandom, 1);
      wb_write(0, 32'h11111111, 1);
      wb_write(1, 32'h22222222, 1);
      wb_write(2, 32'h33333333, 1);
      wb_write(3, 32'h44444444, 1);
      wb_read(2, 32'h33333333, "t1_read2");
      wb_rw(5, 32'h5A5A5A5A);
      wb_read(5, 32'h5A5A5A5A, "t1_read5");

      rdy_mode = 0;
      start_stream(12, 0, nb);
      wait_valid;
      wait_done(nb);
      chk("t2_blk0", acc_q[0], {64'h1111111122222222, 4'd8, 1'b0});
      chk("t2_blk1", acc_q[1], {64'h3333333300000000, 4'd4, 1'b1});

      start_stream(8, 0, nb);
      wait_valid;
      wait_done(nb);
      chk("t3_count", acc_q.size(), 2);
      chk("t3_blk0_size_last", {acc_q[0].s, acc_q[0].l}, {4'd8, 1'b0});
      chk("t3_blk1", acc_q[1], {64'h0, 4'd0, 1'b1});

      ct_rand = 0;
      ct_delay = 2;
      ct_fixed = 64'hAABBCCDD_EEFF0011;
      start_stream(4, 1, nb);
      wait_valid;
      wait_done(nb);
      chk("t4_ct_count", ct_blk, 1);
      wb_read(0, 32'hAABBCCDD, "t4_mem0");
      wb_read(1, 32'h00000000, "t4_mem1");

      rdy_mode = 2;
      start_stream(16, 0, nb);
      wait_valid;
      first_d = blk_data;
      first_s = blocksize;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("t5_stall_data", blk_data, first_d);
         chk("t5_stall_size", blocksize, first_s);
      end
      wb_write(0, 32'hDEADBEEF, 0);
      wb_read(3, 32'h0, "t5_busy_read");
      start = 1;
      datalen = 8'd200;
      tick;
      start = 0;
      tick;
      chk("t5_err_busy", err, 0);
      rdy_mode = 0;
      wait_done(nb);
      wb_read(0, mem_m[0], "t5_mem0_kept");

      start = 1;
      datalen = 8'd128;
      tick;
      start = 0;
      chk("t6_err", err, 1);
      chk("t6_busy", busy, 0);
      tick;
      chk("t6_err_pulse", err, 0);
      chk("t6_idle", busy, 0);

      rdy_mode = 2;
      start_stream(20, 0, nb);
      wait_valid;
      nRST = 0;
      @(negedge clk);
      chk("t6_reset_outs", {wb_rdata, wb_rvalid, blk_valid, blk_data, blocksize, blk_last, ct_ready, busy, done, err}, 0);
      tick;
      nRST = 1;
      exp_q.delete();
      rdy_mode = 0;
      tick;
      chk("t6_no_done", {busy, done}, 0);
      for (int a = 0; a < 6; a++) wb_read(a, mem_m[a], "t6_mem_kept");

      rdy_mode = 1;
      ct_rand = 1;
      for (int it = 0; it < 14; it++) begin
         repeat (4) wb_write(int'($urandom_range(0, 31)), $urandom, 1);
         wb_rw(int'($urandom_range(0, 31)), $urandom);
         len = int'($urandom_range(0, 140));
         ctm = 1'($urandom_range(0, 1));
         if (len > 127) begin
            start = 1;
            datalen = 8'(len);
            tick;
            start = 0;
            chk("rand_err", {err, busy}, 2'b10);
            tick;
         end else begin
            start_stream(len, ctm, nb);
            wait_valid;
            wait_done(nb);
         end
         repeat (3) begin
            len = int'($urandom_range(0, 31));
            wb_read(len, mem_m[len], "rand_mem");
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule
